// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write burst master.
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Ceiling log2 for elaboration-time constants such as awsize.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// Frame address generator: holds the frame base and running offset,
// wraps the offset at the end of each frame and pulses frame_done.
module ddr_wr_addr_gen
    import ddr_wr_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int BURST_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_done,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] frame_bytes,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_BYTES);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] next_offset;

    // A new frame picks up frame_base directly so the first burst
    // does not have to wait for base_q to be loaded.
    assign burst_addr  = ((offset == '0) ? frame_base : base_q) + offset;
    assign next_offset = offset + STEP;

    // Base capture at frame start, offset advance and wrap on each B response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            offset     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start && offset == '0) begin
                base_q <= frame_base;
            end
            if (resp_done) begin
                if (next_offset >= frame_bytes) begin
                    offset     <= '0;
                    frame_done <= 1'b1;
                end else begin
                    offset <= next_offset;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_wr_burst_master.sv
// Pops words from the write prefetch FIFO and emits fixed-length AXI4
// INCR write bursts into a wrapping frame buffer.
// Optional feature macro: DDR_WR_BRESP_CHECK_EN (sticky bresp_err on
// non-OKAY write responses; tied low when undefined).
//
// state | meaning
// IDLE  | waiting for enable and a full burst of FIFO data
// ADDR  | awvalid held with a stable awaddr
// DATA  | streaming beats straight from the FIFO head
// RESP  | bready held until the B response arrives
module ddr_wr_burst_master
    import ddr_wr_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 28,
    parameter int BURST_LEN = 16,
    parameter int LEVEL_W   = 10
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   frame_base,
    input  logic [ADDR_W-1:0]   frame_bytes,
    input  logic [DATA_W-1:0]   fifo_rd_data,
    input  logic                fifo_rd_vld,
    output logic                fifo_rd_en,
    input  logic [LEVEL_W-1:0]  fifo_level,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                busy,
    output logic                frame_done,
    output logic                bresp_err
);

    localparam int         BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [7:0] LAST_BEAT   = 8'(BURST_LEN - 1);

    wr_state_t         state;
    logic [7:0]        beat_cnt;
    logic              data_st;
    logic              start;
    logic              beat;
    logic              resp_done;
    logic [ADDR_W-1:0] burst_addr;

    assign data_st   = (state == ST_DATA);
    assign start     = (state == ST_IDLE) && enable &&
                       (32'(fifo_level) >= 32'(BURST_LEN));
    assign resp_done = (state == ST_RESP) && bvalid;

    // W channel is a straight pass-through of the FIFO head while in DATA,
    // so a beat and a FIFO pop are the same event.
    assign wvalid     = data_st && fifo_rd_vld;
    assign fifo_rd_en = data_st && wready;
    assign wdata      = data_st ? fifo_rd_data : '0;
    assign wlast      = data_st && (beat_cnt == LAST_BEAT);
    assign beat       = wvalid && wready;

    assign awvalid = (state == ST_ADDR);
    assign bready  = (state == ST_RESP);
    assign busy    = (state != ST_IDLE);

    assign awlen   = LAST_BEAT;
    assign awsize  = 3'(clog2(DATA_W / 8));
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = '1;

    ddr_wr_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_BYTES (BURST_BYTES)
    ) u_addr_gen (
        .clk         (rd_clk),
        .rst         (rd_rst),
        .start       (start),
        .resp_done   (resp_done),
        .frame_base  (frame_base),
        .frame_bytes (frame_bytes),
        .burst_addr  (burst_addr),
        .frame_done  (frame_done)
    );

    // Burst sequencing: IDLE -> ADDR -> DATA -> RESP -> IDLE.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)                  state <= ST_ADDR;
                ST_ADDR: if (awready)                state <= ST_DATA;
                ST_DATA: if (beat && wlast)          state <= ST_RESP;
                ST_RESP: if (bvalid)                 state <= ST_IDLE;
                default:                             state <= ST_IDLE;
            endcase
        end
    end

    // awaddr is captured once per burst and held through the AW handshake.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            awaddr <= '0;
        end else if (start) begin
            awaddr <= burst_addr;
        end
    end

    // Beat counter within the current burst; wlast decodes its last value.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= wlast ? 8'd0 : beat_cnt + 8'd1;
        end
    end

`ifdef DDR_WR_BRESP_CHECK_EN
    // Sticky error on any non-OKAY response; the burst still completes.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            bresp_err <= 1'b0;
        end else if (resp_done && bresp != AXI_RESP_OKAY) begin
            bresp_err <= 1'b1;
        end
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^bresp;
    assign bresp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Self-checking bench for ddr_wr_burst_master (DATA_W=32, BURST_LEN=16).
module tb_ddr_wr_burst_master;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 28;
    localparam int BURST_LEN = 16;
    localparam int LEVEL_W   = 10;

`ifdef DDR_WR_BRESP_CHECK_EN
    localparam bit EXP_STICKY = 1'b1;
`else
    localparam bit EXP_STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [ADDR_W-1:0] frame_bytes = '0;
    logic [31:0]       fifo_rd_data;
    logic              fifo_rd_vld;
    logic              fifo_rd_en;
    logic [9:0]        fifo_level;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready = 1'b0;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready = 1'b0;
    logic [1:0]        bresp = 2'b00;
    logic              bvalid = 1'b0;
    logic              bready;
    logic              busy;
    logic              frame_done;
    logic              bresp_err;

    always #5 clk = ~clk;

    ddr_wr_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .LEVEL_W(LEVEL_W)
    ) dut (
        .rd_clk(clk), .rd_rst(rst), .enable(enable),
        .frame_base(frame_base), .frame_bytes(frame_bytes),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
        .fifo_rd_en(fifo_rd_en), .fifo_level(fifo_level),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy), .frame_done(frame_done), .bresp_err(bresp_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model: word i holds A000_0000+i ----------------
    logic [31:0] mem [0:1023];
    logic [9:0]  rd_ptr = '0;
    logic [9:0]  wr_ptr = '0;
    logic        bubble = 1'b0;
    logic        lvl_ovr_en = 1'b0;
    logic [9:0]  lvl_ovr = '0;
    logic        pop_q = 1'b0;

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);

    assign fifo_rd_data = mem[rd_ptr];
    assign fifo_rd_vld  = (rd_ptr != wr_ptr) && !bubble;
    assign fifo_level   = lvl_ovr_en ? lvl_ovr : (wr_ptr - rd_ptr);

    always @(negedge clk) pop_q = fifo_rd_vld && fifo_rd_en;
    always @(posedge clk) begin
        #1;
        if (pop_q) rd_ptr = rd_ptr + 10'd1;
    end

    // ---------------- AXI slave model ----------------
    int       aw_delay = 0;
    int       aw_wait  = 0;
    bit       w_toggle = 1'b0;
    logic [1:0] bresp_val = 2'b00;

    always @(posedge clk) begin
        #1;
        if (awvalid) aw_wait++; else aw_wait = 0;
        awready = awvalid && (aw_wait > aw_delay);
        wready  = w_toggle ? ~wready : 1'b1;
        bvalid  = bready;
        bresp   = bresp_val;
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_addr_ph = 0, m_data_ph = 0, m_resp_ph = 0, m_fd = 0, m_err = 0;
    logic [27:0] m_off = '0, m_base = '0, m_addr = '0;
    int          bib = 0, beat_idx = 0, b_count = 0, aw_count = 0, fd_count = 0;
    int          gap_cnt = 0, gap_last = 0, awv_cycles = 0, awv_last = 0, pops_burst = 0;
    logic [27:0] aw_log [0:63];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_wlast", wlast, 0);
            chk("rst_bready", bready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_bresp_err", bresp_err, 0);
            chk("rst_awaddr", awaddr, 0);
            chk("rst_wdata", wdata, 0);
            chk("rst_awlen", awlen, 15);
            chk("rst_awsize", awsize, 2);
            chk("rst_awburst", awburst, 1);
            chk("rst_wstrb", wstrb, 4'hF);
            m_addr_ph = 0; m_data_ph = 0; m_resp_ph = 0; m_fd = 0; m_err = 0;
            m_off = '0; m_base = '0; bib = 0;
        end else begin
            chk("awvalid", awvalid, m_addr_ph);
            chk("wvalid", wvalid, m_data_ph && fifo_rd_vld);
            chk("fifo_rd_en", fifo_rd_en, m_data_ph && wready);
            chk("bready", bready, m_resp_ph);
            chk("busy", busy, m_addr_ph || m_data_ph || m_resp_ph);
            chk("frame_done", frame_done, m_fd);
            chk("bresp_err", bresp_err, m_err);
            if (awvalid) begin
                chk("awaddr", awaddr, m_addr);
                chk("awlen", awlen, 15);
                chk("awsize", awsize, 2);
                chk("awburst", awburst, 1);
                chk("wstrb", wstrb, 4'hF);
            end
            if (m_data_ph && wvalid) chk("wlast", wlast, bib == BURST_LEN - 1);
            if (frame_done) fd_count++;

            m_fd = 0;
            if (m_data_ph && !wvalid) gap_cnt++;
            if (m_addr_ph) awv_cycles++;
            if (fifo_rd_vld && fifo_rd_en) pops_burst++;

            if (!m_addr_ph && !m_data_ph && !m_resp_ph && enable && fifo_level >= 10'd16) begin
                if (m_off == '0) m_base = frame_base;
                m_addr = m_base + m_off;
                m_addr_ph = 1; gap_cnt = 0; awv_cycles = 0; pops_burst = 0;
            end else if (m_addr_ph && awvalid && awready) begin
                aw_log[aw_count] = awaddr;
                aw_count++;
                awv_last = awv_cycles;
                m_addr_ph = 0; m_data_ph = 1;
            end else if (m_data_ph && wvalid && wready) begin
                chk("wdata", wdata, 32'hA000_0000 + 32'(beat_idx));
                beat_idx++;
                bib++;
                if (bib == BURST_LEN) begin
                    chk("pops_per_burst", pops_burst, BURST_LEN);
                    gap_last = gap_cnt;
                    bib = 0; m_data_ph = 0; m_resp_ph = 1;
                end
            end else if (m_resp_ph && bvalid) begin
                m_resp_ph = 0;
                if (m_off + 28'd64 >= frame_bytes) begin
                    m_off = '0; m_fd = 1;
                end else begin
                    m_off = m_off + 28'd64;
                end
`ifdef DDR_WR_BRESP_CHECK_EN
                if (bresp != 2'b00) m_err = 1;
`endif
                b_count++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n);
        wr_ptr = wr_ptr + 10'(n);
    endtask

    task automatic wait_bursts(input int n);
        int cyc;
        cyc = 0;
        while (b_count < n && cyc < 3000) begin tick(); cyc++; end
        if (b_count < n) begin
            total++; bad++;
            $display("FAIL wait_bursts: got %0d bursts expected %0d", b_count, n);
        end
    endtask

    task automatic wait_bib(input int k);
        int cyc;
        cyc = 0;
        while (!(m_data_ph && bib == k) && cyc < 3000) begin tick(); cyc++; end
        if (!(m_data_ph && bib == k)) begin
            total++; bad++;
            $display("FAIL wait_beat: got beat %0d expected %0d", bib, k);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        frame_base  = 28'h100;
        frame_bytes = 28'd128;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic: two bursts fill the frame, third wraps to base.
        push(32);
        enable = 1'b1;
        wait_bursts(2);
        repeat (3) tick();
        chk("basic_aw0", aw_log[0], 28'h100);
        chk("basic_aw1", aw_log[1], 28'h140);
        chk("basic_frame_done_cnt", fd_count, 1);
        push(16);
        wait_bursts(3);
        repeat (3) tick();
        chk("basic_aw2", aw_log[2], 28'h100);
        chk("basic_frame_done_cnt2", fd_count, 1);

        // Level gating.
        lvl_ovr_en = 1'b1;
        lvl_ovr    = 10'd15;
        push(16);
        repeat (8) tick();
        chk("lvl_no_aw", aw_count, 3);
        lvl_ovr = 10'd16;
        @(negedge clk);
        chk("lvl_awvalid_pre", awvalid, 0);
        @(negedge clk);
        chk("lvl_awvalid_post", awvalid, 1);
        tick();
        lvl_ovr_en = 1'b0;
        wait_bursts(4);
        chk("lvl_aw3", aw_log[3], 28'h140);

        // FIFO bubble at beat 7.
        push(16);
        wait_bib(7);
        bubble = 1'b1;
        repeat (3) tick();
        bubble = 1'b0;
        wait_bursts(5);
        chk("bubble_gap", gap_last, 3);
        chk("bubble_aw4", aw_log[4], 28'h100);

        // Slave backpressure.
        aw_delay = 5;
        w_toggle = 1'b1;
        push(16);
        wait_bursts(6);
        chk("bp_awvalid_cycles", awv_last, 6);
        chk("bp_aw5", aw_log[5], 28'h140);
        aw_delay = 0;
        w_toggle = 1'b0;

        // Enable dropped mid-burst.
        push(32);
        wait_bib(4);
        enable = 1'b0;
        wait_bursts(7);
        repeat (20) tick();
        chk("stop_aw_count", aw_count, 7);
        chk("stop_busy", busy, 0);

        // Reset mid-burst; next frame restarts at the new base.
        frame_base = 28'h2000;
        enable = 1'b1;
        wait_bib(8);
        pulse_rst();
        push(16);
        wait_bursts(8);
        chk("rst_aw_abandoned", aw_log[7], 28'h140);
        chk("rst_aw_restart", aw_log[8], 28'h2000);

        // Error response handling.
        bresp_val = 2'b10;
        push(16);
        wait_bursts(9);
        repeat (2) tick();
        chk("bresp_err_set", bresp_err, EXP_STICKY);
        bresp_val = 2'b00;
        push(8);
        wait_bursts(10);
        repeat (2) tick();
        chk("bresp_err_hold", bresp_err, EXP_STICKY);
        chk("bresp_aw9", aw_log[9], 28'h2040);
        enable = 1'b0;
        pulse_rst();
        tick();
        chk("bresp_err_clear", bresp_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
